// File: rtl/frame_stat_tracker_pkg.sv
// frame_stat_pkg
//   Shared definitions for the frame statistics tracker.
//   - DEF_DW / DEF_FRAME_LEN : default sample width and frame length
//   - state_e                : controller states, 2-bit encoding
package frame_stat_pkg;

  localparam int DEF_DW        = 4;
  localparam int DEF_FRAME_LEN = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

endpackage

// File: rtl/frame_stat_tracker_if.sv
// frame_stat_tracker_if
//   Groups the frame-start request, the sample stream and the result stream.
//   Ports (by modport, "slave" is the tracker side):
//     start, thresh        frame start request and its threshold
//     in_valid, in_data    sample stream, in_ready back-pressure
//     out_valid, out_ready result handshake
//     max_val, min_val     frame extremes
//     n_gt, n_eq, n_lt     per-class sample counts
//     busy                 frame in progress or result pending
interface frame_stat_tracker_if
  import frame_stat_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = $clog2(DEF_FRAME_LEN + 1)
);

  logic             start;
  logic [DW-1:0]    thresh;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    max_val;
  logic [DW-1:0]    min_val;
  logic [CNT_W-1:0] n_gt;
  logic [CNT_W-1:0] n_eq;
  logic [CNT_W-1:0] n_lt;
  logic             busy;

  // Producer of samples and consumer of results
  modport master (
    output start, thresh, in_valid, in_data, out_ready,
    input  in_ready, out_valid, max_val, min_val, n_gt, n_eq, n_lt, busy
  );

  // The tracker itself
  modport slave (
    input  start, thresh, in_valid, in_data, out_ready,
    output in_ready, out_valid, max_val, min_val, n_gt, n_eq, n_lt, busy
  );

endinterface

// File: rtl/frame_stat_tracker_mag_cmp.sv
// mag_cmp
//   Combinational three-way unsigned magnitude compare of a_i against b_i.
//   Ports:
//     a_i, b_i  operands (DW bits, unsigned)
//     gt_o      a_i > b_i
//     eq_o      a_i == b_i
//     lt_o      a_i < b_i
module mag_cmp
  import frame_stat_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          gt_o,
  output logic          eq_o,
  output logic          lt_o
);

  assign gt_o = (a_i >  b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/frame_stat_tracker.sv
// frame_stat_tracker
//   Collects a frame of FRAME_LEN unsigned samples, classifies each against a
//   threshold captured when the frame starts, tracks the frame max/min and
//   offers {max, min, n_gt, n_eq, n_lt} on a valid/ready result handshake.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    frame_stat_tracker_if.slave (start/thresh, sample stream,
//            result stream, busy)
module frame_stat_tracker
  import frame_stat_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  frame_stat_tracker_if.slave bus
);

  localparam int              IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [DW-1:0]    ALL_ONES = {DW{1'b1}};

  state_e           state_q, state_d;
  logic [DW-1:0]    thresh_q, thresh_d;
  logic [DW-1:0]    max_q, max_d;
  logic [DW-1:0]    min_q, min_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic accept;
  logic thGt, thEq, thLt;
  logic mxGt, mxEq, mxLt;
  logic mnGt, mnEq, mnLt;
  logic unused_flags;

  // Classification against the captured threshold
  mag_cmp #(.DW(DW)) u_cmp_thresh (
    .a_i(bus.in_data), .b_i(thresh_q), .gt_o(thGt), .eq_o(thEq), .lt_o(thLt)
  );

  // Running-max update: strictly greater only, ties leave max unchanged
  mag_cmp #(.DW(DW)) u_cmp_max (
    .a_i(bus.in_data), .b_i(max_q), .gt_o(mxGt), .eq_o(mxEq), .lt_o(mxLt)
  );

  // Running-min update: strictly less only, ties leave min unchanged
  mag_cmp #(.DW(DW)) u_cmp_min (
    .a_i(bus.in_data), .b_i(min_q), .gt_o(mnGt), .eq_o(mnEq), .lt_o(mnLt)
  );

  assign unused_flags = mxEq | mxLt | mnGt | mnEq;

  // Handshake flags are pure state decodes so they react in the cycle the
  // state changes, while all result fields come straight from registers.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == REPORT);
  assign bus.busy      = (state_q != IDLE);
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.max_val = max_q;
  assign bus.min_val = min_q;
  assign bus.n_gt    = gt_q;
  assign bus.n_eq    = eq_q;
  assign bus.n_lt    = lt_q;

  // State and statistics registers; min resets to all-ones so the first
  // sample of a frame always replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      thresh_q <= '0;
      max_q    <= '0;
      min_q    <= ALL_ONES;
      gt_q     <= '0;
      eq_q     <= '0;
      lt_q     <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      thresh_q <= thresh_d;
      max_q    <= max_d;
      min_q    <= min_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state and statistics update. Start is only looked at in IDLE, so a
  // start that coincides with the result handshake just returns to IDLE.
  // idx is not advanced on the final accept; it is cleared at the next start.
  always_comb begin
    state_d  = state_q;
    thresh_d = thresh_q;
    max_d    = max_q;
    min_d    = min_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    idx_d    = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          thresh_d = bus.thresh;
          max_d    = '0;
          min_d    = ALL_ONES;
          gt_d     = '0;
          eq_d     = '0;
          lt_d     = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (thGt)      gt_d = gt_q + CNT_W'(1);
          else if (thEq) eq_d = eq_q + CNT_W'(1);
          else if (thLt) lt_d = lt_q + CNT_W'(1);
          if (mxGt) max_d = bus.in_data;
          if (mnLt) min_d = bus.in_data;
          if (idx_q == LAST_IDX) state_d = REPORT;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      REPORT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
